// File: rtl/regfile_fwd_pkg.sv
// Shared definitions for the register file with forwarding: bus widths,
// enable encodings and the read-source select used by the forwarding mux.
package regfile_fwd_pkg;

  localparam int DataW  = 32;
  localparam int AddrW  = 5;
  localparam int RegNum = 32;

  typedef logic [DataW-1:0] RegBus;
  typedef logic [AddrW-1:0] RegAddrBus;

  localparam logic      RstEnable    = 1'b1;
  localparam logic      WriteEnable  = 1'b1;
  localparam logic      WriteDisable = 1'b0;
  localparam logic      ReadEnable   = 1'b1;
  localparam logic      ReadDisable  = 1'b0;
  localparam RegBus     ZeroWord     = 32'h0000_0000;
  localparam RegAddrBus NOPRegAddr   = 5'b00000;

  // Which producer supplies a read port's data this cycle.
  typedef enum logic [2:0] {
    SRC_ZERO  = 3'd0,
    SRC_EX    = 3'd1,
    SRC_MEM   = 3'd2,
    SRC_WB    = 3'd3,
    SRC_ARRAY = 3'd4
  } fwd_src_e;

endpackage : regfile_fwd_pkg

// File: rtl/regfile_fwd_fwd_mux.sv
// Per-port forwarding select: picks the youngest in-flight value for one read
// port and flags a load-use hazard when that value is an unfinished load.
module fwd_mux
  import regfile_fwd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              rst,
  input  logic              ren,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_waddr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              ex_is_load,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic [DATA_W-1:0] array_word,
  output logic [DATA_W-1:0] rdata,
  output logic              hazard
);

  fwd_src_e sel_s;
  logic     raddr_zero_s;
  logic     ex_hit_s;
  logic     mem_hit_s;
  logic     wb_hit_s;

  assign raddr_zero_s = (raddr == {ADDR_W{1'b0}});
  assign ex_hit_s     = (ex_we == WriteEnable) && (ex_waddr == raddr);
  assign mem_hit_s    = (mem_we == WriteEnable) && (mem_waddr == raddr);
  assign wb_hit_s     = (wb_we == WriteEnable) && (wb_waddr == raddr);

  // Priority select: a pending load in EX is skipped so the port falls through.
  always_comb begin
    sel_s = SRC_ZERO;
    if (rst == RstEnable) begin
      sel_s = SRC_ZERO;
    end else if (ren == ReadDisable) begin
      sel_s = SRC_ZERO;
    end else if (raddr_zero_s) begin
      sel_s = SRC_ZERO;
    end else if (ex_hit_s && !ex_is_load) begin
      sel_s = SRC_EX;
    end else if (mem_hit_s) begin
      sel_s = SRC_MEM;
    end else if (wb_hit_s) begin
      sel_s = SRC_WB;
    end else begin
      sel_s = SRC_ARRAY;
    end
  end

  // Hazard only for an enabled, non-zero read matching a load still in EX.
  always_comb begin
    hazard = 1'b0;
    if (rst == RstEnable) begin
      hazard = 1'b0;
    end else if ((ren == ReadEnable) && !raddr_zero_s && ex_hit_s && ex_is_load) begin
      hazard = 1'b1;
    end else begin
      hazard = 1'b0;
    end
  end

  // Data steering for the selected source.
  always_comb begin
    rdata = {DATA_W{1'b0}};
    case (sel_s)
      SRC_ZERO:  rdata = {DATA_W{1'b0}};
      SRC_EX:    rdata = ex_wdata;
      SRC_MEM:   rdata = mem_wdata;
      SRC_WB:    rdata = wb_wdata;
      SRC_ARRAY: rdata = array_word;
      default:   rdata = {DATA_W{1'b0}};
    endcase
  end

endmodule : fwd_mux

// File: rtl/regfile_fwd.sv
// 32x32 register file with EX/MEM forwarding, WB write-through, load-use
// stall request and a saturating stall-cycle counter.
module regfile_fwd
  import regfile_fwd_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_waddr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              ex_is_load,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              stallreq,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic [CNT_W-1:0]  stall_cnt_r;
  logic              hazard1_s;
  logic              hazard2_s;
  logic              cnt_full_s;

  // Register array; entry 0 is never written so it stays zero after reset.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if ((we == WriteEnable) && (waddr != {ADDR_W{1'b0}})) begin
      regs_r[waddr] <= wdata;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd1 (
    .rst        (rst),
    .ren        (re1),
    .raddr      (raddr1),
    .ex_we      (ex_we),
    .ex_waddr   (ex_waddr),
    .ex_wdata   (ex_wdata),
    .ex_is_load (ex_is_load),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .wb_we      (we),
    .wb_waddr   (waddr),
    .wb_wdata   (wdata),
    .array_word (regs_r[raddr1]),
    .rdata      (rdata1),
    .hazard     (hazard1_s)
  );

  fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd2 (
    .rst        (rst),
    .ren        (re2),
    .raddr      (raddr2),
    .ex_we      (ex_we),
    .ex_waddr   (ex_waddr),
    .ex_wdata   (ex_wdata),
    .ex_is_load (ex_is_load),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .wb_we      (we),
    .wb_waddr   (waddr),
    .wb_wdata   (wdata),
    .array_word (regs_r[raddr2]),
    .rdata      (rdata2),
    .hazard     (hazard2_s)
  );

  assign stallreq   = hazard1_s | hazard2_s;
  assign cnt_full_s = (stall_cnt_r == {CNT_W{1'b1}});

  // Stall-cycle counter; holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stallreq && !cnt_full_s) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = stall_cnt_r;

endmodule : regfile_fwd

// File: tb/tb_regfile_fwd.sv
// Scoreboard bench for regfile_fwd: directed stimulus queues expectations
// tagged with a cycle; a negedge monitor pops and compares them.
module tb_regfile_fwd;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          re1 = 1'b0;
  logic [AW-1:0] raddr1 = '0;
  logic          re2 = 1'b0;
  logic [AW-1:0] raddr2 = '0;
  logic          ex_we = 1'b0;
  logic [AW-1:0] ex_waddr = '0;
  logic [DW-1:0] ex_wdata = '0;
  logic          ex_is_load = 1'b0;
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_waddr = '0;
  logic [DW-1:0] mem_wdata = '0;

  logic [DW-1:0] rdata1, rdata2, rdata1_sat, rdata2_sat;
  logic          stallreq, stallreq_sat;
  logic [31:0]   stall_cnt;
  logic [3:0]    stall_cnt_sat;

  always #5 clk = ~clk;

  regfile_fwd u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .stallreq(stallreq), .stall_cnt(stall_cnt)
  );

  regfile_fwd #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1_sat),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2_sat),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .stallreq(stallreq_sat), .stall_cnt(stall_cnt_sat)
  );

  localparam int S_RD1 = 0, S_RD2 = 1, S_STALL = 2, S_CNT = 3, S_CNT4 = 4;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(int sig);
    case (sig)
      S_RD1:   return rdata1;
      S_RD2:   return rdata2;
      S_STALL: return {31'd0, stallreq};
      S_CNT:   return stall_cnt;
      S_CNT4:  return {28'd0, stall_cnt_sat};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle; stale ones are errors.
  always @(negedge clk) begin
    exp_t keep[$];
    keep = {};
    foreach (sb_q[i]) begin
      if (sb_q[i].cyc == cyc) begin
        checks++;
        if (actual(sb_q[i].sig) !== sb_q[i].val) begin
          errors++;
          $display("FAIL %s: got %h, expected %h", sb_q[i].name, actual(sb_q[i].sig), sb_q[i].val);
        end
      end else if (sb_q[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: never sampled", sb_q[i].name);
      end else begin
        keep.push_back(sb_q[i]);
      end
    end
    sb_q = keep;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_now(int sig, logic [31:0] val, string name);
    exp_t e;
    e.cyc = cyc; e.sig = sig; e.val = val; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic exp_next(int sig, logic [31:0] val, string name);
    exp_t e;
    e.cyc = cyc + 1; e.sig = sig; e.val = val; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    ex_we = 1'b0; ex_waddr = '0; ex_wdata = '0; ex_is_load = 1'b0;
    mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
  endtask

  task automatic load_use_r9();
    ex_we = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd9; ex_wdata = 32'h5555_5555;
    re2 = 1'b1; raddr2 = 5'd9;
  endtask

  initial begin
    // Reset cycle with conflicting activity: outputs must be forced to zero.
    step();
    idle(); rst = 1'b1;
    we = 1'b1; waddr = 5'd3; wdata = 32'h0000_0033;
    re1 = 1'b1; raddr1 = 5'd3;
    load_use_r9();
    exp_now(S_RD1, 32'h0, "rst_rdata1");
    exp_now(S_RD2, 32'h0, "rst_rdata2");
    exp_now(S_STALL, 32'h0, "rst_stallreq");
    step();
    idle(); re1 = 1'b1; raddr1 = 5'd3;
    exp_now(S_RD1, 32'h0, "rst_blocks_write");
    exp_now(S_CNT, 32'h0, "rst_stall_cnt");

    // Write r5, see it from the array, then reset clears it.
    step();
    idle(); we = 1'b1; waddr = 5'd5; wdata = 32'h0000_1234;
    step();
    idle(); re1 = 1'b1; raddr1 = 5'd5;
    exp_now(S_RD1, 32'h0000_1234, "r5_array");
    step();
    idle(); rst = 1'b1; re1 = 1'b1; raddr1 = 5'd5;
    step();
    idle(); re1 = 1'b1; raddr1 = 5'd5;
    exp_now(S_RD1, 32'h0, "r5_cleared");
    exp_now(S_CNT, 32'h0, "cnt_after_rst");

    // Register 0 ignores writes and write-through.
    step();
    idle(); we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; re1 = 1'b1; raddr1 = 5'd0;
    exp_now(S_RD1, 32'h0, "r0_no_writethrough");
    step();
    idle(); re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
    exp_now(S_RD1, 32'h0, "r0_port1");
    exp_now(S_RD2, 32'h0, "r0_port2");

    // Forward priority on r7: EX > MEM > WB > array.
    step();
    idle(); re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
    we = 1'b1; waddr = 5'd7; wdata = 32'h1;
    ex_we = 1'b1; ex_waddr = 5'd7; ex_wdata = 32'h3;
    mem_we = 1'b1; mem_waddr = 5'd7; mem_wdata = 32'h2;
    exp_now(S_RD1, 32'h3, "fwd_ex");
    exp_now(S_RD2, 32'h3, "fwd_ex_port2");
    step();
    ex_we = 1'b0;
    exp_now(S_RD1, 32'h2, "fwd_mem");
    step();
    mem_we = 1'b0;
    exp_now(S_RD1, 32'h1, "fwd_wb");
    step();
    idle(); re1 = 1'b1; raddr1 = 5'd7;
    exp_now(S_RD1, 32'h1, "r7_array");

    // Disabled read returns zero even for a populated register.
    step();
    idle(); we = 1'b1; waddr = 5'd4; wdata = 32'h0000_ABCD;
    step();
    idle(); re1 = 1'b0; raddr1 = 5'd4; re2 = 1'b1; raddr2 = 5'd4;
    exp_now(S_RD1, 32'h0, "re1_disabled");
    exp_now(S_RD2, 32'h0000_ABCD, "r4_port2");

    // Load-use on r9 via port 2 for three cycles.
    for (int k = 0; k < 3; k++) begin
      step();
      idle(); load_use_r9();
      exp_now(S_STALL, 32'h1, $sformatf("loaduse_stall%0d", k));
      exp_now(S_CNT, k, $sformatf("loaduse_cnt%0d", k));
    end
    step();
    idle(); load_use_r9(); re2 = 1'b0;
    exp_now(S_STALL, 32'h0, "loaduse_re2_off");
    exp_now(S_CNT, 32'd3, "cnt_after_3");
    exp_now(S_CNT4, 32'd3, "cnt4_after_3");

    // A load flag without a write enable is inert; EX is not a match.
    step();
    idle(); ex_is_load = 1'b1; ex_waddr = 5'd4; ex_wdata = 32'h9999_9999;
    re1 = 1'b1; raddr1 = 5'd4;
    exp_now(S_STALL, 32'h0, "load_no_we");
    exp_now(S_RD1, 32'h0000_ABCD, "load_no_we_data");

    // Load targeting r0 never stalls.
    step();
    idle(); ex_we = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd0; re1 = 1'b1; raddr1 = 5'd0;
    exp_now(S_STALL, 32'h0, "load_r0");
    exp_now(S_RD1, 32'h0, "load_r0_data");

    // Fourteen more stall cycles: 17 total, the 4-bit counter sticks at 15.
    for (int k = 0; k < 14; k++) begin
      step();
      idle(); load_use_r9();
    end
    exp_next(S_CNT, 32'd17, "cnt_17");
    exp_next(S_CNT4, 32'd15, "cnt4_saturated");

    // Reset during a stall.
    step();
    idle(); load_use_r9(); rst = 1'b1;
    exp_now(S_STALL, 32'h0, "rst_during_stall");
    exp_now(S_RD2, 32'h0, "rst_during_stall_rd");
    step();
    idle();
    exp_now(S_CNT, 32'h0, "cnt_rst_mid");
    exp_now(S_CNT4, 32'h0, "cnt4_rst_mid");

    step();
    step();
    if (sb_q.size() != 0) begin
      checks += sb_q.size();
      errors += sb_q.size();
      $display("FAIL scoreboard: %0d expectations left unchecked", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_regfile_fwd
